seq_shift_unit: RTL and testbench

- Iterative multi-cycle shifter for the EX stage of the pipelined RISC-V core. Executes SLL/SRL/SRA (and SLLI/SRLI/SRAI) using a single-bit-per-cycle datapath instead of a full barrel shifter.
- Sits between the ID/EX register and the EX/MEM result mux.
- Uses a valid/ready handshake on both sides so the hazard unit can stall the pipeline while a shift is in flight.

---
 rtl/seq_shift_unit.sv | 145 ++++++++++++++
 tb/tb_seq_shift_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_shift_unit
// Purpose  : Iterative multi-cycle shifter for the EX stage. It executes
//            SLL/SRL/SRA (and the immediate forms) one bit per clock rather
//            than through a full barrel shifter. A valid/ready handshake on
//            both sides lets the hazard unit stall the pipeline while a
//            shift is in flight.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            in_valid/ready - request handshake (op, operand, shamt)
//            op             - 00 SLL, 01 SRL, 10 SRA, 11 pass-through
//            operand        - value to shift (rs1)
//            shamt          - shift amount
//            out_valid/ready- result handshake
//            result         - shifted value (registered)
//            busy           - high in SHIFT or DONE; pipeline stall
// Options  : `define SEQ_SHIFT_STEP4_EN to shift by 4 per clock while the
//            remaining count is at least 4
// Revision : 1.0 - initial release
// ============================================================================
module seq_shift_unit #(
    parameter int N       = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [N-1:0]       operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       result,
    output logic               busy
);

    localparam logic [1:0] c_OP_SLL  = 2'b00;
    localparam logic [1:0] c_OP_SRL  = 2'b01;
    localparam logic [1:0] c_OP_SRA  = 2'b10;
    localparam logic [1:0] c_OP_PASS = 2'b11;

    localparam logic [SHAMT_W-1:0] c_ONE = SHAMT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [N-1:0]         r_acc;
    logic [SHAMT_W-1:0]   r_cnt;
    logic [1:0]           r_op;

    logic [N-1:0]         w_shift1;
    logic [N-1:0]         w_step_acc;
    logic [SHAMT_W-1:0]   w_cnt_next;

    // Single-bit step; pass-through never reaches SHIFT, so it holds.
    always_comb begin
        w_shift1 = r_acc;
        case (r_op)
            c_OP_SLL: w_shift1 = {r_acc[N-2:0], 1'b0};
            c_OP_SRL: w_shift1 = {1'b0, r_acc[N-1:1]};
            c_OP_SRA: w_shift1 = {r_acc[N-1], r_acc[N-1:1]};
            default:  w_shift1 = r_acc;
        endcase
    end

`ifdef SEQ_SHIFT_STEP4_EN
    localparam logic [SHAMT_W-1:0] c_FOUR = SHAMT_W'(4);

    logic [N-1:0] w_shift4;
    logic         w_big_step;

    always_comb begin
        w_shift4 = r_acc;
        case (r_op)
            c_OP_SLL: w_shift4 = {r_acc[N-5:0], 4'b0000};
            c_OP_SRL: w_shift4 = {4'b0000, r_acc[N-1:4]};
            c_OP_SRA: w_shift4 = {{4{r_acc[N-1]}}, r_acc[N-1:4]};
            default:  w_shift4 = r_acc;
        endcase
    end

    // Take the 4-bit stride while at least 4 bits remain, then finish
    // the residue one bit at a time.
    assign w_big_step = (r_cnt >= c_FOUR);
    assign w_step_acc = w_big_step ? w_shift4 : w_shift1;
    assign w_cnt_next = w_big_step ? (r_cnt - c_FOUR) : (r_cnt - c_ONE);
`else
    assign w_step_acc = w_shift1;
    assign w_cnt_next = r_cnt - c_ONE;
`endif

    // SHIFT is entered only with a non-zero count, so the count reaching
    // zero on this step is the exit condition and never underflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= c_OP_SLL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_acc <= operand;
                        r_op  <= op;
                        r_cnt <= shamt;
                        if ((shamt == '0) || (op == c_OP_PASS)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_acc <= w_step_acc;
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == '0) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // All outputs decode directly from registers. The accumulator is the
    // result register: it is only meaningful while out_valid is high, and
    // it is held there because DONE does not touch it.
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign result    = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_shift_unit
// Purpose  : Self-checking bench for seq_shift_unit. A table of requests
//            with expected results is applied in a loop; expected result
//            and latency are queued when a request is driven and popped
//            when out_valid appears. Hand-written sequences cover reset
//            behaviour, backpressure and asynchronous reset mid-shift.
// Options  : honours `define SEQ_SHIFT_STEP4_EN for expected latency
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_shift_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    seq_shift_unit #(.N(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand   (operand),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] operand;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Number of clock edges after acceptance until out_valid is seen.
    function automatic int exp_lat(input logic [1:0] o, input logic [4:0] s);
        if (s == 5'd0 || o == 2'b11) return 0;
`ifdef SEQ_SHIFT_STEP4_EN
        return int'(s) / 4 + int'(s) % 4;
`else
        return int'(s);
`endif
    endfunction

    task automatic run_vec(input logic [1:0] o, input logic [31:0] d,
                           input logic [4:0] s, input logic [31:0] exp, input string name);
        exp_t e;
        int   w;
        int   edges;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({name, " in_ready idle"}, 32'(in_ready), 32'd1);
        op        = o;
        operand   = d;
        shamt     = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        e.res = exp;
        e.lat = exp_lat(o, s);
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Keep in_valid high with different data: it must not be re-sampled.
        operand = ~d;
        shamt   = s ^ 5'h1F;
        op      = o ^ 2'b01;
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        chk({name, " out_valid"}, 32'(out_valid), 32'd1);
        chk({name, " latency"}, 32'(edges), 32'(e.lat));
        chk({name, " result"}, result, e.res);
        chk({name, " busy in DONE"}, 32'(busy), 32'd1);
        chk({name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk({name, " out_valid released"}, 32'(out_valid), 32'd0);
        chk({name, " busy released"}, 32'(busy), 32'd0);
        chk({name, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int edges;
        vecs[0]  = '{op: 2'b00, operand: 32'h0000_0001, shamt: 5'd12, exp: 32'h0000_1000};
        vecs[1]  = '{op: 2'b10, operand: 32'h8000_0000, shamt: 5'd31, exp: 32'hFFFF_FFFF};
        vecs[2]  = '{op: 2'b01, operand: 32'h8000_0000, shamt: 5'd31, exp: 32'h0000_0001};
        vecs[3]  = '{op: 2'b00, operand: 32'hDEAD_BEEF, shamt: 5'd0,  exp: 32'hDEAD_BEEF};
        vecs[4]  = '{op: 2'b11, operand: 32'hDEAD_BEEF, shamt: 5'd7,  exp: 32'hDEAD_BEEF};
        vecs[5]  = '{op: 2'b10, operand: 32'h7FFF_0000, shamt: 5'd16, exp: 32'h0000_7FFF};
        vecs[6]  = '{op: 2'b10, operand: 32'hF000_0000, shamt: 5'd5,  exp: 32'hFF80_0000};
        vecs[7]  = '{op: 2'b00, operand: 32'h0000_0001, shamt: 5'd13, exp: 32'h0000_2000};
        vecs[8]  = '{op: 2'b00, operand: 32'hFFFF_FFFF, shamt: 5'd31, exp: 32'h8000_0000};
        vecs[9]  = '{op: 2'b01, operand: 32'hDEAD_BEEF, shamt: 5'd1,  exp: 32'h6F56_DF77};
        vecs[10] = '{op: 2'b10, operand: 32'h8000_0000, shamt: 5'd3,  exp: 32'hF000_0000};

        // Reset state, with a request presented during reset.
        rst       = 1'b1;
        in_valid  = 1'b1;
        op        = 2'b00;
        operand   = 32'h1234_5678;
        shamt     = 5'd3;
        out_ready = 1'b0;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset result", result, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("no transfer in reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        chk("post reset idle", 32'(in_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i].op, vecs[i].operand, vecs[i].shamt, vecs[i].exp,
                    $sformatf("vec%0d", i));
        end

        // Backpressure: DONE holds while out_ready stays low.
        @(negedge clk);
        op        = 2'b01;
        operand   = 32'hF000_0000;
        shamt     = 5'd4;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("bp latency", 32'(edges), 32'(exp_lat(2'b01, 5'd4)));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp result", result, 32'h0F00_0000);
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        chk("bp release out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        op       = 2'b00;
        operand  = 32'h0000_0001;
        shamt    = 5'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("mid-shift busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst result", result, 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_vec(2'b00, 32'h0000_0003, 5'd1, 32'h0000_0006, "after rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
